// File: rtl/ram_sequencer.sv
// ram_sequencer: burst initiator for a small synchronous RAM.
// Accepts write/read burst commands on a valid/ready port. Write bursts pull words
// from a write stream and pulse the RAM write enable. Read bursts drive the RAM
// output enable, capture the registered read data and present it on a read stream.
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   cmd_valid/cmd_ready         command handshake (ready only in IDLE)
//   cmd_write/cmd_addr/cmd_len  burst direction, start address, words-1
//   wr_valid/wr_ready/wr_data   write stream input
//   rd_valid/rd_ready/rd_data   read stream output (valid/data registered)
//   busy                        sequencer not idle
//   mem_we/mem_oe/mem_addr/mem_wdata/mem_rdata  RAM pins
module ram_sequencer #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [ADDR_W-1:0] cmd_len,
  input  logic              wr_valid,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  input  logic              rd_ready,
  output logic              busy,
  output logic              mem_we,
  output logic              mem_oe,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    RD_ISSUE,
    RD_CAPTURE,
    RD_HOLD
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]   rd_data_q, rd_data_d;
  logic                rd_valid_q, rd_valid_d;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      cnt_q      <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  // Next-state and RAM control decode
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = rd_valid_q;
    cmd_ready  = 1'b0;
    wr_ready   = 1'b0;
    mem_we     = 1'b0;
    mem_oe     = 1'b0;
    mem_wdata  = '0;

    case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          addr_d  = cmd_addr;
          cnt_d   = cmd_len;
          state_d = cmd_write ? WRITE : RD_ISSUE;
        end
      end
      WRITE: begin
        wr_ready = 1'b1;
        mem_we   = wr_valid;
        if (wr_valid) begin
          addr_d = ADDR_W'(addr_q + 1'b1);
          cnt_d  = ADDR_W'(cnt_q - 1'b1);
          if (cnt_q == '0) state_d = IDLE;
        end
      end
      RD_ISSUE: begin
        mem_oe  = 1'b1;
        state_d = RD_CAPTURE;
      end
      RD_CAPTURE: begin
        // RAM output is driven only while mem_oe is high, so sample it here
        mem_oe     = 1'b1;
        rd_data_d  = mem_rdata;
        rd_valid_d = 1'b1;
        state_d    = RD_HOLD;
      end
      RD_HOLD: begin
        if (rd_ready) begin
          rd_valid_d = 1'b0;
          if (cnt_q == '0) begin
            state_d = IDLE;
          end else begin
            addr_d  = ADDR_W'(addr_q + 1'b1);
            cnt_d   = ADDR_W'(cnt_q - 1'b1);
            state_d = RD_ISSUE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Suppress RAM strobes in the reset cycle so a mid-burst reset never writes
    if (rst) begin
      mem_we = 1'b0;
      mem_oe = 1'b0;
    end
    if (mem_we) mem_wdata = wr_data;
  end

  assign busy     = (state_q != IDLE);
  assign mem_addr = addr_q;
  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;

endmodule

// File: doc/ram_sequencer.md
# ram_sequencer

Bus initiator for the 16-word x 2-bit synchronous RAM. It takes burst commands on a valid/ready port and moves data over a streaming interface. For writes it pulls words from a write stream and pulses the RAM write enable. For reads it drives the RAM output enable, captures the registered read data and presents it on a read stream. It sits between test/control logic and the RAM, and is the only driver of the RAM's `we`, `oe`, `addr` and `data_in` pins.

## Interface
- `ADDR_W`, default 4: RAM address width; the burst length field uses the same width.
- `DATA_W`, default 2: RAM word width.

- `clk` in 1: single clock; every register updates on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `cmd_valid` in 1: command offered.
- `cmd_ready` out 1: high only in IDLE; a command is accepted when `cmd_valid & cmd_ready`.
- `cmd_write` in 1: 1 = write burst, 0 = read burst.
- `cmd_addr` in ADDR_W: start address.
- `cmd_len` in ADDR_W: number of words minus 1 (0..15 gives 1..16 words).
- `wr_valid` in 1, `wr_data` in DATA_W: write stream input.
- `wr_ready` out 1: high only in state WRITE.
- `rd_valid` out 1, `rd_data` out DATA_W: read stream output (both registered).
- `rd_ready` in 1: read stream consumer ready.
- `busy` out 1: state != IDLE.
- `mem_we` out 1, `mem_oe` out 1, `mem_addr` out ADDR_W, `mem_wdata` out DATA_W: RAM controls.
- `mem_rdata` in DATA_W: RAM `data_out`. It is high-Z whenever `mem_oe` = 0 and must not be sampled then.

## Operation
- **State machine:** IDLE, WRITE, RD_ISSUE, RD_CAPTURE, RD_HOLD.
- **Internal registers:** `addr_q` (ADDR_W), `cnt_q` (ADDR_W, words remaining minus 1), `rd_data_q`.
- **IDLE**
  - On command accept: `addr_q` <= `cmd_addr`, `cnt_q` <= `cmd_len`.
  - Next state is WRITE if `cmd_write` = 1, else RD_ISSUE.
- **WRITE**
  - `mem_we` = `wr_valid` (combinational). `mem_addr` = `addr_q`. `mem_wdata` = `wr_data` while `mem_we` = 1, else 0.
  - On each `wr_valid`: `addr_q` += 1 (mod 2^ADDR_W); `cnt_q` -= 1.
  - If `cnt_q` was 0 at that handshake, go to IDLE.
  - `wr_valid` = 0 stalls with no RAM write and no counter change.
- **RD_ISSUE:** `mem_oe` = 1, `mem_addr` = `addr_q`; the RAM latches `mem[addr_q]` at the closing edge. Next state RD_CAPTURE.
- **RD_CAPTURE**
  - `mem_oe` = 1 and `mem_addr` are held, so the RAM output is driven and valid.
  - `rd_data_q` <= `mem_rdata`, `rd_valid` <= 1. Next state RD_HOLD.
- **RD_HOLD**
  - `mem_oe` = 0, `rd_valid` = 1, `rd_data` stable.
  - On `rd_ready`: `rd_valid` <= 0. If `cnt_q` = 0, go to IDLE. Otherwise `addr_q` += 1, `cnt_q` -= 1, and go to RD_ISSUE.
- **Outside the active states:** `mem_we` = 0, `mem_oe` = 0, `mem_wdata` = 0, and `mem_addr` holds `addr_q`.
- **Address wrap:** address 15 + 1 = 0. A burst of length 16 from address 5 covers 5..15 and then 0..4.
- **Exclusive enables:** `mem_we` and `mem_oe` are never both 1 in the same cycle.

## Timing
- **Reset values:** state IDLE, `cmd_ready` = 1, `busy` = 0, `wr_ready` = 0, `rd_valid` = 0, `rd_data` = 0, `mem_we` = 0, `mem_oe` = 0, `mem_addr` = 0, `mem_wdata` = 0.
- **Reset mid-burst** (any state): state returns to IDLE at the next edge. No RAM write occurs in the reset cycle. A pending `rd_valid` drops and the remaining words are discarded.
- **Write latency:** command accepted at edge T gives `wr_ready` = 1 in cycle T+1. With `wr_valid` held high, one word is written per cycle, so an N-word burst is back in IDLE at T+1+N.
- **Read latency:** command accepted at T gives RD_ISSUE in cycle T+1, RD_CAPTURE in T+2, and `rd_valid` = 1 from T+3.
  - With `rd_ready` held high, each word takes 3 cycles.
  - An N-word read returns to IDLE at T+3N+1.
- **Back-to-back commands:** `cmd_ready` rises in the first IDLE cycle, so commands accepted back to back have at least one IDLE cycle between them.
- **Simultaneous events:** `cmd_valid` during a burst is ignored (`cmd_ready` = 0). `rd_ready` is don't-care while `rd_valid` = 0. `wr_valid` is don't-care outside WRITE.

## Test plan
- **Single write then read:** reset; write addr 3, len 0, data 2'b10; then read addr 3, len 0. Expect exactly one `mem_we` pulse at `mem_addr` = 3, then `rd_valid` with `rd_data` = 2'b10 three cycles after acceptance.
- **Full wrap burst:** write addr 14, len 15, data = address index mod 4. Expect `mem_addr` sequence 14, 15, 0 … 13. Reading back the same burst returns the matching data.
- **Stalls:** write burst with `wr_valid` toggling 1, 0, 0, 1 gives exactly 2 writes, with `mem_we` = 0 in stall cycles. Read with `rd_ready` low for 5 cycles keeps `rd_valid`/`rd_data` stable and `mem_oe` = 0 throughout.
- **Reset mid-read:** assert `rst` while in RD_HOLD of the 2nd word of a 4-word read. Expect `rd_valid` = 0, `busy` = 0, `cmd_ready` = 1 next cycle, and no further `mem_oe`.
- **Protocol checker throughout all tests:**
  - `mem_we & mem_oe` never high together.
  - `mem_rdata` sampled only when `mem_oe` = 1.
  - `cmd_ready` = !`busy`.
